fifo_ctrl: RTL and testbench
============================

FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, payload width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, RAM address width; RAM depth D = 2^ADDR_WIDTH.
REQ-003 SHALL have port clock  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_data  input  DATA_WIDTH  write payload.
REQ-006 SHALL have port in_valid  input  1  producer offers in_data.
REQ-007 SHALL have port in_ready  output  1  controller accepts in_data this cycle.
REQ-008 SHALL have port out_data  output  DATA_WIDTH  head-of-queue payload.
REQ-009 SHALL have port out_valid  output  1  out_data holds a valid entry.
REQ-010 SHALL have port out_ready  input  1  consumer takes out_data this cycle.
REQ-011 SHALL have port level  output  ADDR_WIDTH+1  total occupancy, present only under FIFO_CTRL_LEVEL_EN.

Function
REQ-012 SHALL sequence one registered-read simple dual-port RAM of D x DATA_WIDTH plus one output stage; total capacity D+1 entries.
REQ-013 SHALL keep write pointer wptr and read pointer rptr, each ADDR_WIDTH+1 bits, wrapping modulo 2^(ADDR_WIDTH+1); ram_count = wptr - rptr (modulo arithmetic, 0..D).
REQ-014 SHALL drive in_ready = (ram_count < D) and not reset; a push occurs when in_valid and in_ready: RAM write at wptr[ADDR_WIDTH-1:0], wptr increments.
REQ-015 SHALL issue a fetch (RAM read enable, address rptr[ADDR_WIDTH-1:0], rptr increments) when ram_count > 0 and (out_valid == 0 or out_ready == 1).
REQ-016 SHALL set out_valid to 1 the cycle after a fetch; clear it when out_valid and out_ready and no fetch in the same cycle; otherwise hold it.
REQ-017 SHALL present out_data directly from the RAM read register, held stable while out_valid is 1 and out_ready is 0; out_data is don't-care while out_valid is 0.
REQ-018 SHALL compute ram_count from registered pointers only, so a word pushed in cycle N is fetchable no earlier than N+1; write and read of the same address in one cycle never occur.
REQ-019 SHALL give empty-queue latency of exactly 2 cycles: push at N -> out_valid at N+2.
REQ-020 SHALL sustain one push and one pop per cycle in steady state with no bubbles.
REQ-021 SHALL ignore in_valid when in_ready is 0 (no pointer or RAM change); in_ready does not depend on out_ready (full means RAM full, regardless of a simultaneous fetch).
REQ-022 SHALL preserve strict FIFO order across pointer wrap-around.

Reset
REQ-023 SHALL on reset set wptr = 0, rptr = 0, out_valid = 0, in_ready = 0, level = 0; RAM contents are not cleared.
REQ-024 SHALL on reset asserted mid-operation discard all queued entries and any fetch in flight; first cycle after reset in_ready = 1, out_valid = 0.

Configuration
REQ-025 SHALL with macro FIFO_CTRL_LEVEL_EN defined provide port level = ram_count + out_valid, registered-consistent with the same cycle's pointers, range 0..D+1.
REQ-026 SHALL without FIFO_CTRL_LEVEL_EN omit port level and its adder; all other behaviour identical.

Structure
REQ-027 SHALL place the pointer-width and depth localparams (PTR_WIDTH = ADDR_WIDTH+1, DEPTH) in shared package fifo_pkg.
REQ-028 SHALL instantiate exactly one sub-module, simple_dual_port_ram_reg1, as the storage, with all sequencing in fifo_ctrl.

Verification (DATA_WIDTH=8, ADDR_WIDTH=2, D=4, capacity 5)
REQ-029 SHALL cover: reset, push 0xA5 at cycle 0 with out_ready=0 -> out_valid=1, out_data=0xA5 at cycle 2, held until out_ready=1.
REQ-030 SHALL cover: out_ready=0, push 0x01..0x06 back-to-back -> 5 accepted, in_ready=0 on 6th, level=5; then drain -> 0x01..0x05 in order.
REQ-031 SHALL cover: in_valid=1 and out_ready=1 continuously for 20 cycles with incrementing data -> one output per cycle after 2-cycle latency, no gaps, order preserved across 4+ pointer wraps.
REQ-032 SHALL cover: full (level=5), pop one -> in_ready returns 1 next cycle after the refetch frees a RAM slot; level=4.
REQ-033 SHALL cover: reset asserted with 3 entries queued and a fetch in flight -> next cycle out_valid=0, level=0, in_ready=1; subsequent push 0x3C emerges first.
REQ-034 SHALL cover: random in_valid/out_ready at 50% for 1000 cycles against a reference queue model -> zero mismatches, no overflow or underflow.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the FIFO controller and its storage RAM.
// Pointers carry one extra wrap bit so that full and empty can be told apart.
package fifo_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned DEFAULT_ADDR_WIDTH = 4;

    // Values for the default configuration; instances derive theirs through the functions.
    localparam int unsigned PTR_WIDTH = DEFAULT_ADDR_WIDTH + 1;
    localparam int unsigned DEPTH     = 1 << DEFAULT_ADDR_WIDTH;

    function automatic int unsigned ptr_width(input int unsigned addr_width);
        return addr_width + 1;
    endfunction

    function automatic int unsigned depth(input int unsigned addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/simple_dual_port_ram_reg1.sv
// Simple dual-port RAM, one write port and one read port with a registered read.
// Contents are not reset; read data holds its value when no read is enabled.
module simple_dual_port_ram_reg1
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    localparam int unsigned Depth = depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [Depth];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller: a registered-read RAM plus the RAM read register as output stage.
// Optional occupancy port `level` is built only when FIFO_CTRL_LEVEL_EN is defined.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef FIFO_CTRL_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]   level
`endif
);

    localparam int unsigned PtrWidth = ptr_width(ADDR_WIDTH);
    localparam logic [PtrWidth-1:0] DepthPtr = PtrWidth'(depth(ADDR_WIDTH));

    logic [PtrWidth-1:0] wptr_q, wptr_d;
    logic [PtrWidth-1:0] rptr_q, rptr_d;
    logic [PtrWidth-1:0] ram_count;
    logic                out_valid_q, out_valid_d;
    logic                push;
    logic                fetch;

    // Registered pointers only: a word written this cycle is not readable until the next,
    // which also keeps the write and read addresses apart whenever both ports are active.
    always_comb begin
        ram_count = wptr_q - rptr_q;
        in_ready  = (ram_count < DepthPtr) && !reset;
        push      = in_valid && in_ready;
        fetch     = (ram_count != '0) && (!out_valid_q || out_ready) && !reset;

        wptr_d = wptr_q;
        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end

        rptr_d = rptr_q;
        if (fetch) begin
            rptr_d = rptr_q + 1'b1;
        end

        out_valid_d = out_valid_q;
        if (fetch) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;

`ifdef FIFO_CTRL_LEVEL_EN
    assign level = ram_count + PtrWidth'(out_valid_q);
`endif

    simple_dual_port_ram_reg1 #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk_i     (clock),
        .wr_en_i   (push),
        .wr_addr_i (wptr_q[ADDR_WIDTH-1:0]),
        .wr_data_i (in_data),
        .rd_en_i   (fetch),
        .rd_addr_i (rptr_q[ADDR_WIDTH-1:0]),
        .rd_data_o (out_data)
    );

    ram_count_bounded: assert property (@(posedge clock) disable iff (reset)
        ram_count <= DepthPtr);

    no_same_addr_rw: assert property (@(posedge clock) disable iff (reset)
        !(push && fetch && (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0])));

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed-vector and scoreboard bench for fifo_ctrl with ADDR_WIDTH=2 (capacity 5).
// Level is compared only in builds that define FIFO_CTRL_LEVEL_EN.
module tb_fifo_ctrl;

    localparam int DW = 8;
    localparam int AW = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
`ifdef FIFO_CTRL_LEVEL_EN
    logic [AW:0]   level;
`endif

    always #5 clock = ~clock;

    fifo_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef FIFO_CTRL_LEVEL_EN
        ,
        .level     (level)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic check_level(input string name, input int expected);
`ifdef FIFO_CTRL_LEVEL_EN
        check(name, int'(level), expected);
`endif
    endtask

    typedef struct {
        logic          rst;
        logic          iv;
        logic [DW-1:0] din;
        logic          ordy;
        logic          ir;
        logic          ov;
        logic [DW-1:0] dout;
        int            lvl;
    } vec_t;

    vec_t vecs[$];
    logic [DW-1:0] q[$];

    task automatic drive(input logic r, input logic iv, input logic [DW-1:0] d, input logic ordy);
        reset     = r;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        @(negedge clock);
    endtask

    task automatic next_edge();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // rst iv din ordy | in_ready out_valid out_data level
        vecs.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 0});
        vecs.push_back('{1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h00, 0});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 1});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 1});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 1});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 0});
        // fill to capacity with out_ready low
        vecs.push_back('{1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 8'h00, 0});
        vecs.push_back('{1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 8'h00, 1});
        vecs.push_back('{1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 8'h01, 2});
        vecs.push_back('{1'b0, 1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 8'h01, 3});
        vecs.push_back('{1'b0, 1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 8'h01, 4});
        vecs.push_back('{1'b0, 1'b1, 8'h06, 1'b0, 1'b0, 1'b1, 8'h01, 5});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h01, 5});
        // pop one from full: in_ready returns on the following cycle
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h01, 5});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h02, 4});
        // drain
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h02, 4});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h03, 3});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h04, 2});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h05, 1});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0});

        repeat (2) @(posedge clock);
        #1;

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].iv, vecs[i].din, vecs[i].ordy);
            check($sformatf("v%0d in_ready", i), int'(in_ready), int'(vecs[i].ir));
            check($sformatf("v%0d out_valid", i), int'(out_valid), int'(vecs[i].ov));
            if (vecs[i].ov) begin
                check($sformatf("v%0d out_data", i), int'(out_data), int'(vecs[i].dout));
            end
            check_level($sformatf("v%0d level", i), vecs[i].lvl);
            next_edge();
        end

        // streaming: push and pop every cycle, 24 words wrap the pointers six times
        for (int i = 0; i < 27; i++) begin
            drive(1'b0, (i < 24), 8'(8'h40 + i), 1'b1);
            check($sformatf("stream%0d in_ready", i), int'(in_ready), 1);
            check($sformatf("stream%0d out_valid", i), int'(out_valid), int'(i >= 2 && i < 26));
            if (i >= 2 && i < 26) begin
                check($sformatf("stream%0d out_data", i), int'(out_data), 8'h40 + i - 2);
            end
            check_level($sformatf("stream%0d level", i),
                        (i == 0 || i == 26) ? 0 : (i == 1 || i == 25) ? 1 : 2);
            next_edge();
        end

        // reset while three entries are queued and a fetch would be issued
        drive(1'b0, 1'b1, 8'h11, 1'b0); next_edge();
        drive(1'b0, 1'b1, 8'h22, 1'b0); next_edge();
        drive(1'b0, 1'b1, 8'h33, 1'b0); next_edge();
        drive(1'b1, 1'b0, 8'h00, 1'b1);
        check("midrst in_ready during reset", int'(in_ready), 0);
        check("midrst head before reset", int'(out_data), 8'h11);
        check_level("midrst level before reset", 3);
        next_edge();
        drive(1'b0, 1'b1, 8'h3C, 1'b0);
        check("midrst out_valid after", int'(out_valid), 0);
        check("midrst in_ready after", int'(in_ready), 1);
        check_level("midrst level after", 0);
        next_edge();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        check("midrst out_valid n+1", int'(out_valid), 0);
        next_edge();
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        check("midrst out_valid n+2", int'(out_valid), 1);
        check("midrst first out", int'(out_data), 8'h3C);
        next_edge();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        check("midrst empty again", int'(out_valid), 0);
        next_edge();

        // random traffic against a reference queue
        begin
            int stall = 0;
            for (int c = 0; c < 1000; c++) begin
                drive(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
                if (q.size() <= 3) check("rand in_ready free", int'(in_ready), 1);
                if (q.size() == 5) check("rand in_ready full", int'(in_ready), 0);
                if (q.size() == 0) check("rand underflow", int'(out_valid), 0);
                check_level("rand level", q.size());
                if (out_valid && out_ready && q.size() > 0) begin
                    check("rand out_data", int'(out_data), int'(q.pop_front()));
                end
                if (in_valid && in_ready) q.push_back(in_data);
                check("rand overflow", int'(q.size() <= 5), 1);
                stall = (!out_valid && q.size() > 0) ? stall + 1 : 0;
                check("rand stall", int'(stall <= 2), 1);
                next_edge();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
